serial_data_rx: RTL

- Serial-to-parallel receive stage that sits directly upstream of the parallel data interface.
- Deserialises an asynchronous serial frame: 1 start bit, 8 data bits LSB first, 1 parity bit, 1 stop bit.
- Drives data_valid, data and parity_error toward the parallel data consumer.
- Flags stop-bit failures on a separate frame_error output.

---
 rtl/serial_rx_pkg.sv | 21 ++
 rtl/bit_sync.sv | 27 ++
 rtl/serial_data_rx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receive stage.
// Holds the frame geometry, the FSM state type and the parity helper.
package serial_rx_pkg;

    localparam int DATA_W          = 8;
    localparam int FRAME_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity bit a correct transmitter would append to d.
    function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input.
// RESET_VAL sets the value both flops take while rst is high.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/serial_data_rx.sv
// Serial-to-parallel receiver: start bit, 8 data bits LSB first, parity, stop.
// Bits are sampled mid-cell using a sample counter restarted at each sample point.
module serial_data_rx
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic              data_valid,
    output logic [DATA_W-1:0] data,
    output logic              parity_error,
    output logic              frame_error,
    output logic              rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic sync_in;
    logic sync_d_q;

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_error_q, parity_error_d;
    logic              frame_error_q, frame_error_d;
    logic              at_mid;
    logic              at_full;

    bit_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (sync_in)
    );

    assign at_mid  = (cnt_q == CW'(CLKS_PER_BIT/2 - 1));
    assign at_full = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + CW'(1);
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        par_d          = par_q;
        data_d         = data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        frame_error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Only a real high-to-low transition starts a frame, so a held-low break is ignored.
                if (sync_d_q && !sync_in) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (at_mid) begin
                    cnt_d   = '0;
                    state_d = sync_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_full) begin
                    cnt_d     = '0;
                    shift_d   = {sync_in, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (at_full) begin
                    cnt_d   = '0;
                    par_d   = sync_in;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_full) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync_in) begin
                        data_d         = shift_q;
                        data_valid_d   = 1'b1;
                        parity_error_d = (par_q != calc_parity(shift_q, 1'(PARITY_ODD)));
                    end else begin
                        frame_error_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_d_q       <= 1'b1;
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            par_q          <= 1'b0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            sync_d_q       <= sync_in;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign data_valid   = data_valid_q;
    assign data         = data_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign rx_busy      = (state_q != IDLE);

endmodule
